// File: rtl/imhotep_pkg.sv
// rtl/imhotep_pkg.sv - shared core constants and data-memory controller types
//
// Purpose: machine width, data-RAM address width, and the state encoding and
// default read latency of the data-memory controller.
// Ports: none (package).
package imhotep_pkg;

  localparam int XLEN          = 32;
  // One bit wider than a 1024-word RAM needs, so out-of-range word
  // addresses can be expressed and flagged.
  localparam int RAM_WIDTH     = 11;
  localparam int DMEM_READ_LAT = 2;
  localparam int DMEM_DEPTH    = 1024;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_DONE
  } dmem_state_e;

endpackage

// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - LSU to data-memory controller access bus
//
// Purpose: groups the LSU request and controller response signals.
// Signals (named from the controller's point of view):
//   req_i, w_rn_i, addr_i, wdata_i   LSU -> controller
//   rdata_o, rvalid_o, stall_o, error_o   controller -> LSU
// Modports: master (LSU side), slave (controller side).
interface dmem_ctrl_if;
  import imhotep_pkg::*;

  logic                 req_i;
  logic                 w_rn_i;
  logic [RAM_WIDTH-1:0] addr_i;
  logic [XLEN-1:0]      wdata_i;
  logic [XLEN-1:0]      rdata_o;
  logic                 rvalid_o;
  logic                 stall_o;
  logic                 error_o;

  modport master (
    output req_i, w_rn_i, addr_i, wdata_i,
    input  rdata_o, rvalid_o, stall_o, error_o
  );

  modport slave (
    input  req_i, w_rn_i, addr_i, wdata_i,
    output rdata_o, rvalid_o, stall_o, error_o
  );

endinterface

// File: rtl/dmem_ctrl_sram_sp.sv
// rtl/dmem_ctrl_sram_sp.sv - single-port synchronous data SRAM
//
// Purpose: DEPTH x DW word memory; synchronous write, synchronous read with
// one cycle of latency. The read register holds its value while en_i is low.
// Contents are not initialised.
// Ports:
//   clk_i    clock
//   en_i     access enable
//   we_i     1 = write, 0 = read (qualified by en_i)
//   addr_i   word address
//   wdata_i  write data
//   rdata_o  registered read data
module sram_sp #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 32
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory controller between the LSU and the data SRAM
//
// Purpose: single-cycle writes, fixed-latency reads that stall the core for
// READ_LAT cycles, and flagging of out-of-range accesses without executing
// them.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     dmem_ctrl_if.slave: req_i, w_rn_i, addr_i, wdata_i in;
//           rdata_o, rvalid_o (registered), stall_o, error_o (combinational) out
module dmem_ctrl
  import imhotep_pkg::*;
#(
  parameter int READ_LAT = DMEM_READ_LAT,
  parameter int DEPTH    = DMEM_DEPTH
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  dmem_ctrl_if.slave bus
);

  localparam int                 IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [RAM_WIDTH:0] DEPTH_W  = (RAM_WIDTH + 1)'(DEPTH);
  localparam logic [2:0]         CNT_INIT = 3'(READ_LAT - 1);

  dmem_state_e     state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;

  logic            in_range;
  logic            sram_en;
  logic            sram_we;
  logic            stall;
  logic            error;
  logic [XLEN-1:0] sram_rdata;

  // Zero-extended compare so DEPTH = 2**RAM_WIDTH is representable.
  assign in_range = {1'b0, bus.addr_i} < DEPTH_W;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    sram_en  = 1'b0;
    sram_we  = 1'b0;
    stall    = 1'b0;
    error    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          if (!in_range) begin
            error    = 1'b1;
            rdata_d  = '0;
            rvalid_d = 1'b1;
          end else if (bus.w_rn_i) begin
            sram_en = 1'b1;
            sram_we = 1'b1;
          end else begin
            sram_en  = 1'b1;
            stall    = 1'b1;
            cnt_d    = CNT_INIT;
            state_d  = (READ_LAT > 1) ? RD_WAIT : RD_DONE;
            rvalid_d = (READ_LAT == 1);
          end
        end
      end

      RD_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d  = sram_rdata;
          rvalid_d = 1'b1;
          state_d  = RD_DONE;
        end
      end

      RD_DONE: begin
        // The held request is the load completing now; never re-accept it.
        state_d = IDLE;
        // With a one-cycle latency the RAM word arrives in this cycle, so it
        // is forwarded below and latched here to be held afterwards.
        if (READ_LAT == 1) begin
          rdata_d = sram_rdata;
        end
      end

      default: state_d = IDLE;
    endcase

    // While reset is held the core may still present the abandoned load;
    // keep the combinational outputs quiet and block any RAM write.
    if (!rst_ni) begin
      stall   = 1'b0;
      error   = 1'b0;
      sram_en = 1'b0;
      sram_we = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  sram_sp #(
    .DEPTH (DEPTH),
    .AW    (IW),
    .DW    (XLEN)
  ) u_sram (
    .clk_i   (clk_i),
    .en_i    (sram_en),
    .we_i    (sram_we),
    .addr_i  (bus.addr_i[IW-1:0]),
    .wdata_i (bus.wdata_i),
    .rdata_o (sram_rdata)
  );

  assign bus.stall_o  = stall;
  assign bus.error_o  = error;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = (READ_LAT == 1 && state_q == RD_DONE) ? sram_rdata : rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl at READ_LAT 1, 2 and 4
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0;
  logic [2:0]  w_rn = '0;
  logic [10:0] addr_r [3];
  logic [31:0] wdata_r [3];
  logic [31:0] rdata [3];
  logic [2:0]  rvalid;
  logic [2:0]  stall;
  logic [2:0]  err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // DUT 0: READ_LAT=1, DUT 1: READ_LAT=2, DUT 2: READ_LAT=4; all DEPTH=1024.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    dmem_ctrl_if bus_if ();
    dmem_ctrl #(.READ_LAT(L), .DEPTH(1024)) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus_if)
    );
    assign bus_if.req_i   = req[g];
    assign bus_if.w_rn_i  = w_rn[g];
    assign bus_if.addr_i  = addr_r[g];
    assign bus_if.wdata_i = wdata_r[g];
    assign rdata[g]  = bus_if.rdata_o;
    assign rvalid[g] = bus_if.rvalid_o;
    assign stall[g]  = bus_if.stall_o;
    assign err[g]    = bus_if.error_o;
  end

  typedef struct {
    int          sel;
    logic [31:0] data;
  } sb_t;
  sb_t sb[$];
  sb_t e;

  typedef struct {
    bit          rq;
    bit          w;
    logic [10:0] a;
    logic [31:0] d;
    bit          st;
    bit          er;
    bit          rv;
    bit          push;
    logic [31:0] pd;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t v(bit rq, bit w, int a, logic [31:0] d, bit st, bit er,
                             bit rv, bit p, logic [31:0] pd);
    vec_t r;
    r.rq = rq; r.w = w; r.a = 11'(a); r.d = d;
    r.st = st; r.er = er; r.rv = rv; r.push = p; r.pd = pd;
    return r;
  endfunction

  // Scoreboard: every rvalid pops the oldest expected read result.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int s = 0; s < 3; s++) begin
        if (rvalid[s]) begin
          if (sb.size() == 0) begin
            check($sformatf("rvalid_with_empty_scoreboard dut%0d", s), 32'(rvalid[s]), 32'd0);
          end else begin
            e = sb.pop_front();
            check($sformatf("sb_dut_sel dut%0d", s), 32'(s), 32'(e.sel));
            check($sformatf("sb_rdata dut%0d", s), rdata[s], e.data);
          end
        end
      end
    end
  end

  task automatic wr(input int s, input int a, input logic [31:0] d);
    @(posedge clk); #1;
    req[s] = 1'b1; w_rn[s] = 1'b1; addr_r[s] = 11'(a); wdata_r[s] = d;
    @(negedge clk);
    check($sformatf("wr_stall dut%0d", s), 32'(stall[s]), 32'd0);
    check($sformatf("wr_error dut%0d", s), 32'(err[s]), 32'd0);
  endtask

  task automatic rd(input int s, input int a, input logic [31:0] d, input int lat);
    int st;
    bit got;
    @(posedge clk); #1;
    req[s] = 1'b1; w_rn[s] = 1'b0; addr_r[s] = 11'(a);
    sb.push_back('{s, d});
    st = 0;
    got = 1'b0;
    for (int c = 0; c < 16 && !got; c++) begin
      @(negedge clk);
      if (rvalid[s]) got = 1'b1;
      else if (stall[s]) st++;
    end
    check($sformatf("rd_rvalid_seen dut%0d", s), 32'(got), 32'd1);
    check($sformatf("rd_stall_cycles dut%0d", s), 32'(st), 32'(lat));
    check($sformatf("rd_release_stall dut%0d", s), 32'(stall[s]), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      req = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int s = 0; s < 3; s++) begin
      addr_r[s] = '0;
      wdata_r[s] = '0;
    end

    // Table on the READ_LAT=2 DUT: write/read, held load, out-of-range,
    // boundary addresses, back-to-back loads.
    tbl.push_back(v(0, 0, 0,    32'h0,        0, 0, 0, 0, 32'h0));
    tbl.push_back(v(1, 1, 5,    32'hDEADBEEF, 0, 0, 0, 0, 32'h0));
    tbl.push_back(v(1, 0, 5,    32'h0,        1, 0, 0, 1, 32'hDEADBEEF));
    tbl.push_back(v(1, 0, 5,    32'h0,        1, 0, 0, 0, 32'h0));
    tbl.push_back(v(1, 0, 5,    32'h0,        0, 0, 1, 0, 32'h0));
    tbl.push_back(v(0, 0, 0,    32'h0,        0, 0, 0, 0, 32'h0));
    tbl.push_back(v(0, 0, 0,    32'h0,        0, 0, 0, 0, 32'h0));
    tbl.push_back(v(1, 1, 0,    32'h11111111, 0, 0, 0, 0, 32'h0));
    tbl.push_back(v(1, 1, 1023, 32'hCAFEF00D, 0, 0, 0, 0, 32'h0));
    tbl.push_back(v(1, 1, 1024, 32'hBAD0BAD0, 0, 1, 0, 1, 32'h0));
    tbl.push_back(v(1, 0, 1024, 32'h0,        0, 1, 1, 1, 32'h0));
    tbl.push_back(v(0, 0, 0,    32'h0,        0, 0, 1, 0, 32'h0));
    tbl.push_back(v(1, 0, 1023, 32'h0,        1, 0, 0, 1, 32'hCAFEF00D));
    tbl.push_back(v(1, 0, 1023, 32'h0,        1, 0, 0, 0, 32'h0));
    tbl.push_back(v(1, 0, 1023, 32'h0,        0, 0, 1, 0, 32'h0));
    tbl.push_back(v(1, 0, 0,    32'h0,        1, 0, 0, 1, 32'h11111111));
    tbl.push_back(v(1, 0, 0,    32'h0,        1, 0, 0, 0, 32'h0));
    tbl.push_back(v(1, 0, 0,    32'h0,        0, 0, 1, 0, 32'h0));
    tbl.push_back(v(1, 0, 2047, 32'h0,        0, 1, 0, 1, 32'h0));
    tbl.push_back(v(0, 0, 0,    32'h0,        0, 0, 1, 0, 32'h0));
    tbl.push_back(v(1, 1, 7,    32'h00000001, 0, 0, 0, 0, 32'h0));
    tbl.push_back(v(1, 1, 8,    32'h00000002, 0, 0, 0, 0, 32'h0));
    tbl.push_back(v(1, 0, 7,    32'h0,        1, 0, 0, 1, 32'h00000001));
    tbl.push_back(v(1, 0, 7,    32'h0,        1, 0, 0, 0, 32'h0));
    tbl.push_back(v(1, 0, 7,    32'h0,        0, 0, 1, 0, 32'h0));
    tbl.push_back(v(1, 0, 8,    32'h0,        1, 0, 0, 1, 32'h00000002));
    tbl.push_back(v(1, 0, 8,    32'h0,        1, 0, 0, 0, 32'h0));
    tbl.push_back(v(1, 0, 8,    32'h0,        0, 0, 1, 0, 32'h0));
    tbl.push_back(v(0, 0, 0,    32'h0,        0, 0, 0, 0, 32'h0));

    // Reset values.
    #12;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset_rdata dut%0d", s), rdata[s], 32'h0);
      check($sformatf("reset_rvalid dut%0d", s), 32'(rvalid[s]), 32'd0);
      check($sformatf("reset_stall dut%0d", s), 32'(stall[s]), 32'd0);
      check($sformatf("reset_error dut%0d", s), 32'(err[s]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      req[1] = tbl[i].rq; w_rn[1] = tbl[i].w; addr_r[1] = tbl[i].a; wdata_r[1] = tbl[i].d;
      if (tbl[i].push) sb.push_back('{1, tbl[i].pd});
      @(negedge clk);
      check($sformatf("row%0d_stall", i), 32'(stall[1]), 32'(tbl[i].st));
      check($sformatf("row%0d_error", i), 32'(err[1]), 32'(tbl[i].er));
      check($sformatf("row%0d_rvalid", i), 32'(rvalid[1]), 32'(tbl[i].rv));
    end

    // Latency sweep at READ_LAT=1 and READ_LAT=4.
    wr(0, 0, 32'h12345678);
    rd(0, 0, 32'h12345678, 1);
    idle(1);
    wr(2, 0, 32'h12345678);
    rd(2, 0, 32'h12345678, 4);
    idle(3);
    @(negedge clk);
    check("rdata_held_after_read dut2", rdata[2], 32'h12345678);
    check("rvalid_low_after_read dut2", 32'(rvalid[2]), 32'd0);

    // Reset in the RD_WAIT cycle of a READ_LAT=2 load.
    @(posedge clk); #1;
    req[1] = 1'b1; w_rn[1] = 1'b0; addr_r[1] = 11'd9;
    @(posedge clk); #1;
    check("pre_reset_stall dut1", 32'(stall[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midread_reset_stall dut1", 32'(stall[1]), 32'd0);
    check("midread_reset_rvalid dut1", 32'(rvalid[1]), 32'd0);
    check("midread_reset_rdata dut1", rdata[1], 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("held_reset_stall dut1", 32'(stall[1]), 32'd0);
    req = '0;
    rst_n = 1'b1;
    wr(1, 3, 32'hA5A5A5A5);
    rd(1, 3, 32'hA5A5A5A5, 2);
    idle(3);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
